elevator_controller: RTL and testbench
======================================

ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 SHALL have parameter TRAVEL_TICKS, default 3, clk cycles to move one floor (>=1).
REQ-002 SHALL have parameter DOOR_TICKS, default 5, clk cycles the door stays open (>=1).
REQ-003 SHALL have port clk  in  1  divided system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports st_floor_button, nd_floor_button, rd_floor_button  in  1 each  raw level floor calls.
REQ-006 SHALL have port emergency  in  1  halt request from the emergency system.
REQ-007 SHALL have port weight_limit_exceeded  in  1  overload flag from the emergency system.
REQ-008 SHALL have ports st_floor_led, nd_floor_led, rd_floor_led  out  1 each  one-hot current car floor.
REQ-009 SHALL have port door_status_led  out  1  1 = door open.
REQ-010 SHALL have ports moving_up, moving_down  out  1 each  travel direction; never both 1.
REQ-011 SHALL have port pending_calls  out  3  latched calls, bit0 = 1st floor.

Function
REQ-012 SHALL register each button once and set its pending bit on a detected rising edge; pending bit visible one cycle after the edge is sampled.
REQ-013 SHALL implement states IDLE, DOOR_OPEN, MOVE_UP, MOVE_DOWN, HALT.
REQ-014 IDLE: a call at the current floor SHALL go to DOOR_OPEN without latching it; else any pending call above/below SHALL go to MOVE_UP/MOVE_DOWN; nearest wins; equal distance (car at 2nd, calls 1st and 3rd) SHALL choose MOVE_UP.
REQ-015 MOVE_*: a travel counter SHALL count TRAVEL_TICKS cycles, then update the floor by one; if the new floor is pending, clear it and go to DOOR_OPEN; else continue in the same direction while calls remain ahead, else reverse, else IDLE.
REQ-016 SHALL never move past the 1st or 3rd floor.
REQ-017 DOOR_OPEN: door_status_led=1 for DOOR_TICKS cycles, then return to IDLE (direction decision re-evaluated there).
REQ-018 While weight_limit_exceeded=1 in DOOR_OPEN, the door timer SHALL reload and the door stay open; weight_limit_exceeded SHALL block leaving IDLE.
REQ-019 emergency=1 SHALL force HALT next cycle from any state: door closed, moving_* =0, pending_calls cleared, travel/door counters cleared, floor held at last reached floor.
REQ-020 HALT SHALL ignore buttons and exit to IDLE on the cycle after emergency returns to 0.
REQ-021 Simultaneous new edge and clear of the same floor SHALL leave the bit cleared.

Reset
REQ-022 On rst_n=0: state IDLE, floor = 1st (st_floor_led=1, others 0), door_status_led=0, moving_up=moving_down=0, pending_calls=0, counters=0, button edge registers=0.
REQ-023 Reset SHALL take effect immediately mid-operation, including mid-travel and mid-door.

Configuration
REQ-024 Macro ELEVATOR_DOOR_HOLD_EN: when defined, a rising edge on the current floor button during DOOR_OPEN SHALL reload the door timer to DOOR_TICKS; when undefined, such a press SHALL be ignored.

Structure
REQ-025 Package elevator_pkg SHALL hold the state enum, floor one-hot constants (FLOOR_1/2/3) and the direction type.
REQ-026 Sub-module elevator_call_latch SHALL hold button edge detection and the pending register with set/clear ports.

Verification (TRAVEL_TICKS=3, DOOR_TICKS=5)
REQ-027 Reset, car at 1st, pulse rd_floor_button -> pending_calls=3'b100, MOVE_UP, nd_floor_led after 3 cycles, rd_floor_led after 6, pending cleared, door_status_led=1 for exactly 5 cycles, then IDLE.
REQ-028 Car at 2nd idle, pulse st and rd same cycle -> moves up first, serves 3rd, then reverses down to 1st.
REQ-029 Door open at 1st, hold weight_limit_exceeded=1 for 10 cycles -> door stays open 10 cycles, closes 5 cycles after release.
REQ-030 Mid-travel 1st->2nd (cycle 2 of 3), assert emergency -> next cycle HALT, moving_*=0, door=0, st_floor_led=1, pending_calls=0; release -> IDLE.
REQ-031 rst_n low during DOOR_OPEN at 3rd -> outputs immediately equal reset values (st_floor_led=1).
REQ-032 With ELEVATOR_DOOR_HOLD_EN, press current floor button at door cycle 4 -> door open 5 further cycles; without macro -> closes on schedule.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and floor helpers for the three-floor elevator controller.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DOOR_OPEN,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_e;

  localparam logic [2:0] FLOOR_1 = 3'b001;
  localparam logic [2:0] FLOOR_2 = 3'b010;
  localparam logic [2:0] FLOOR_3 = 3'b100;

  function automatic logic [2:0] floors_above(input logic [2:0] f);
    case (f)
      FLOOR_1: floors_above = FLOOR_2 | FLOOR_3;
      FLOOR_2: floors_above = FLOOR_3;
      default: floors_above = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] floors_below(input logic [2:0] f);
    case (f)
      FLOOR_3: floors_below = FLOOR_1 | FLOOR_2;
      FLOOR_2: floors_below = FLOOR_1;
      default: floors_below = 3'b000;
    endcase
  endfunction

  // Saturates at the end floors so the car can never leave the shaft.
  function automatic logic [2:0] step_floor(input logic [2:0] f, input dir_e d);
    step_floor = f;
    if (d == DIR_UP && f != FLOOR_3) step_floor = {f[1:0], 1'b0};
    else if (d == DIR_DOWN && f != FLOOR_1) step_floor = {1'b0, f[2:1]};
  endfunction

endpackage

// File: rtl/elevator_call_latch.sv
// Button rising-edge detection plus the pending-call register; clear wins over a same-cycle set.
module elevator_call_latch
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_i,
  input  logic [2:0] set_en_i,
  input  logic [2:0] clr_i,
  input  logic       clr_all_i,
  output logic [2:0] rise_o,
  output logic [2:0] pending_o
);

  logic [2:0] btn_q;
  logic [2:0] pending_q, pending_d;

  assign rise_o    = btn_i & ~btn_q;
  assign pending_o = pending_q;

  always_comb begin
    pending_d = (pending_q | (rise_o & set_en_i)) & ~clr_i;
    if (clr_all_i) pending_d = 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= 3'b000;
      pending_q <= 3'b000;
    end else begin
      btn_q     <= btn_i;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// Three-floor elevator controller. Define ELEVATOR_DOOR_HOLD_EN to let a press of the
// current floor's button re-open (extend) the door timer.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_TICKS = 3,
  parameter int unsigned DOOR_TICKS   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       st_floor_button,
  input  logic       nd_floor_button,
  input  logic       rd_floor_button,
  input  logic       emergency,
  input  logic       weight_limit_exceeded,
  output logic       st_floor_led,
  output logic       nd_floor_led,
  output logic       rd_floor_led,
  output logic       door_status_led,
  output logic       moving_up,
  output logic       moving_down,
  output logic [2:0] pending_calls
);

  localparam int TW = $clog2(TRAVEL_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);

  state_e        state_q, state_d;
  logic [2:0]    floor_q, floor_d;
  logic [TW-1:0] travel_cnt_q, travel_cnt_d;
  logic [DW-1:0] door_cnt_q, door_cnt_d;

  logic [2:0] rise, pending, set_en, clr, next_floor, ahead, behind;
  logic       clr_all, door_hold;
  dir_e       dir;

  elevator_call_latch u_call_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_i     ({rd_floor_button, nd_floor_button, st_floor_button}),
    .set_en_i  (set_en),
    .clr_i     (clr),
    .clr_all_i (clr_all),
    .rise_o    (rise),
    .pending_o (pending)
  );

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;
    set_en       = 3'b111;
    clr          = 3'b000;
    clr_all      = 1'b0;
    door_hold    = 1'b0;

    dir = DIR_NONE;
    if (state_q == ST_MOVE_UP) dir = DIR_UP;
    else if (state_q == ST_MOVE_DOWN) dir = DIR_DOWN;
    next_floor = step_floor(floor_q, dir);
    ahead  = (dir == DIR_UP) ? floors_above(next_floor) : floors_below(next_floor);
    behind = (dir == DIR_UP) ? floors_below(next_floor) : floors_above(next_floor);

    if (emergency) begin
      state_d      = ST_HALT;
      travel_cnt_d = '0;
      door_cnt_d   = '0;
      set_en       = 3'b000;
      clr_all      = 1'b1;
    end else begin
      case (state_q)
        ST_HALT: begin
          set_en  = 3'b000;
          state_d = ST_IDLE;
        end
        ST_IDLE: begin
          // A call at the car's own floor is served by opening the door, never latched.
          set_en = ~floor_q;
          if (!weight_limit_exceeded) begin
            if (((rise | pending) & floor_q) != 3'b000) begin
              state_d    = ST_DOOR_OPEN;
              door_cnt_d = '0;
              clr        = floor_q;
            end else if ((pending & floors_above(floor_q)) != 3'b000) begin
              state_d      = ST_MOVE_UP;
              travel_cnt_d = '0;
            end else if ((pending & floors_below(floor_q)) != 3'b000) begin
              state_d      = ST_MOVE_DOWN;
              travel_cnt_d = '0;
            end
          end
        end
        ST_DOOR_OPEN: begin
          set_en = ~floor_q;
`ifdef ELEVATOR_DOOR_HOLD_EN
          door_hold = weight_limit_exceeded | ((rise & floor_q) != 3'b000);
`else
          door_hold = weight_limit_exceeded;
`endif
          if (door_hold) begin
            door_cnt_d = '0;
          end else if (door_cnt_q == DOOR_LAST) begin
            door_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            door_cnt_d = door_cnt_q + 1'b1;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (travel_cnt_q == TRAVEL_LAST) begin
            travel_cnt_d = '0;
            floor_d      = next_floor;
            if ((pending & next_floor) != 3'b000) begin
              clr        = next_floor;
              state_d    = ST_DOOR_OPEN;
              door_cnt_d = '0;
            end else if ((pending & ahead) != 3'b000) begin
              state_d = state_q;
            end else if ((pending & behind) != 3'b000) begin
              state_d = (dir == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            travel_cnt_d = travel_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      floor_q      <= FLOOR_1;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
    end
  end

  assign {rd_floor_led, nd_floor_led, st_floor_led} = floor_q;
  assign door_status_led = (state_q == ST_DOOR_OPEN);
  assign moving_up       = (state_q == ST_MOVE_UP);
  assign moving_down     = (state_q == ST_MOVE_DOWN);
  assign pending_calls   = pending;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench: a floor-number reference model predicts every cycle's outputs; a monitor compares.
module tb_elevator_controller;

  localparam int TRAVEL = 3;
  localparam int DOOR   = 5;
`ifdef ELEVATOR_DOOR_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st_b = 1'b0, nd_b = 1'b0, rd_b = 1'b0;
  logic emergency = 1'b0, weight = 1'b0;
  logic st_led, nd_led, rd_led, door_led, mv_up, mv_dn;
  logic [2:0] pend;

  always #5 clk = ~clk;

  elevator_controller #(.TRAVEL_TICKS(TRAVEL), .DOOR_TICKS(DOOR)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .st_floor_button       (st_b),
    .nd_floor_button       (nd_b),
    .rd_floor_button       (rd_b),
    .emergency             (emergency),
    .weight_limit_exceeded (weight),
    .st_floor_led          (st_led),
    .nd_floor_led          (nd_led),
    .rd_floor_led          (rd_led),
    .door_status_led       (door_led),
    .moving_up             (mv_up),
    .moving_down           (mv_dn),
    .pending_calls         (pend)
  );

  // {leds[3rd,2nd,1st], door, up, down, pending[3rd,2nd,1st]}
  typedef logic [8:0] obs_t;
  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle_no = 0;
  bit hold_rst = 1'b1;

  // Reference model: floor as 1..3, direction as +1/-1/0, countdowns of remaining cycles.
  int       m_floor, m_dir, m_travel, m_door;
  bit [3:1] m_pend, m_prev;
  bit       m_halt;

  function automatic void model_reset();
    m_floor = 1; m_dir = 0; m_travel = 0; m_door = 0;
    m_pend = '0; m_prev = '0; m_halt = 1'b0;
  endfunction

  function automatic bit calls_toward(bit [3:1] p, int f, int d);
    for (int g = f + d; g >= 1 && g <= 3; g += d)
      if (p[g]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o[8:6] = 3'(1 << (m_floor - 1));
    o[5]   = (m_door > 0);
    o[4]   = (m_dir == 1);
    o[3]   = (m_dir == -1);
    o[2:0] = m_pend;
    return o;
  endfunction

  function automatic void model_step(logic [2:0] btn, logic emg, logic wt);
    bit [3:1] rise, old;
    for (int i = 1; i <= 3; i++) begin
      rise[i] = btn[i-1] && !m_prev[i];
      m_prev[i] = btn[i-1];
    end
    if (emg) begin
      m_halt = 1'b1; m_dir = 0; m_door = 0; m_travel = 0; m_pend = '0;
      return;
    end
    if (m_halt) begin
      m_halt = 1'b0;
      return;
    end
    old = m_pend;
    if (m_door > 0) begin
      for (int i = 1; i <= 3; i++) if (rise[i] && i != m_floor) m_pend[i] = 1'b1;
      if (wt || (HOLD && rise[m_floor])) m_door = DOOR;
      else m_door--;
    end else if (m_dir != 0) begin
      m_pend = m_pend | rise;
      m_travel--;
      if (m_travel == 0) begin
        m_floor += m_dir;
        if (old[m_floor]) begin
          m_pend[m_floor] = 1'b0;
          m_door = DOOR;
          m_dir = 0;
        end else begin
          if (!calls_toward(old, m_floor, m_dir))
            m_dir = calls_toward(old, m_floor, -m_dir) ? -m_dir : 0;
          if (m_dir != 0) m_travel = TRAVEL;
        end
      end
    end else begin
      for (int i = 1; i <= 3; i++) if (rise[i] && i != m_floor) m_pend[i] = 1'b1;
      if (!wt) begin
        if (rise[m_floor] || old[m_floor]) begin
          m_door = DOOR;
          m_pend[m_floor] = 1'b0;
        end else begin
          // nearest pending floor wins; upward checked first so a tie goes up
          for (int d = 1; d <= 2 && m_dir == 0; d++) begin
            if (m_floor + d <= 3 && old[m_floor + d]) m_dir = 1;
            else if (m_floor - d >= 1 && old[m_floor - d]) m_dir = -1;
          end
          if (m_dir != 0) m_travel = TRAVEL;
        end
      end
    end
  endfunction

  // One clock: drive at the falling edge and queue the prediction for the next rising edge.
  task automatic cyc(input logic [2:0] btn, input logic emg, input logic wt);
    @(negedge clk);
    rst_n = !hold_rst;
    {rd_b, nd_b, st_b} = btn;
    emergency = emg;
    weight = wt;
    if (rst_n) model_step(btn, emg, wt);
    else model_reset();
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'b000, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic [2:0] btn);
    cyc(btn, 1'b0, 1'b0);
  endtask

  // Asserts reset between clock edges; the monitor checks the outputs right away.
  task automatic async_reset_mid_cycle();
    @(posedge clk);
    #3;
    model_reset();
    exp_q.push_back(model_obs());
    hold_rst = 1'b1;
    rst_n = 1'b0;
  endtask

  // Monitor: compares whenever the DUT has produced a new output set.
  initial begin
    obs_t act, want;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        act  = {rd_led, nd_led, st_led, door_led, mv_up, mv_dn, pend};
        checks++;
        if (act !== want) begin
          errors++;
          $display("FAIL outputs cycle %0d: got leds=%b door=%b up=%b dn=%b pend=%b, want leds=%b door=%b up=%b dn=%b pend=%b",
                   cycle_no, act[8:6], act[5], act[4], act[3], act[2:0],
                   want[8:6], want[5], want[4], want[3], want[2:0]);
        end
      end
    end
  end

  initial begin
    int emg_left, wt_left;
    logic [2:0] btn;
    model_reset();
    idle(3);
    hold_rst = 1'b0;
    idle(2);

    // 1st -> 3rd trip, door, idle
    pulse(3'b100); idle(16);
    // back to 1st
    pulse(3'b001); idle(20);
    // new edge at the arrival floor in the same cycle it is cleared
    pulse(3'b100); idle(6); pulse(3'b100); idle(14);
    // to 2nd, then 1st and 3rd together: up first, then down
    pulse(3'b010); idle(12);
    pulse(3'b101); idle(36);
    // weight holds the door at 1st
    pulse(3'b001);
    for (int i = 0; i < 10; i++) cyc(3'b000, 1'b0, 1'b1);
    idle(8);
    // weight in idle blocks departure
    pulse(3'b100);
    for (int i = 0; i < 4; i++) cyc(3'b000, 1'b0, 1'b1);
    idle(3);
    pulse(3'b001); idle(24);
    // current-floor press late in the door period
    pulse(3'b001); idle(2); pulse(3'b001); idle(10);
    // emergency mid-travel 1st -> 2nd
    pulse(3'b010); idle(2);
    cyc(3'b111, 1'b1, 1'b0); cyc(3'b000, 1'b1, 1'b0);
    cyc(3'b100, 1'b0, 1'b0); idle(4);
    idle(20);
    // reset while the door is open at 3rd
    pulse(3'b100); idle(8);
    async_reset_mid_cycle();
    idle(2);
    hold_rst = 1'b0;
    idle(3);

    // randomized traffic
    emg_left = 0; wt_left = 0;
    for (int n = 0; n < 4000; n++) begin
      if (emg_left == 0 && $urandom_range(0, 199) == 0) emg_left = $urandom_range(1, 4);
      if (wt_left == 0 && $urandom_range(0, 59) == 0) wt_left = $urandom_range(1, 12);
      btn = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      cyc(btn, emg_left > 0, wt_left > 0);
      if (emg_left > 0) emg_left--;
      if (wt_left > 0) wt_left--;
      if ($urandom_range(0, 1499) == 0) begin
        async_reset_mid_cycle();
        idle(1);
        hold_rst = 1'b0;
      end
    end
    idle(3);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions never compared, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
